// File: rtl/pkt_rx_pkg.sv
// Shared definitions for the pkt_rx checker: FSM encoding, length defaults,
// internal widths and the mod-to-byte-count helper.
package pkt_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned MIN_LEN_DEF = 64;
  localparam int unsigned MAX_LEN_DEF = 1518;

  // Word counter width and frame-length width (8 * 65535 fits in 19 bits)
  localparam int unsigned WC_W  = 16;
  localparam int unsigned LEN_W = 19;

  // Valid bytes in an eop beat; a mod of 0 means all 8 lanes
  function automatic logic [3:0] mod_bytes(input logic [2:0] mod);
    return (mod == 3'd0) ? 4'd8 : {1'b0, mod};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating accumulator used for every statistic.
// Ports: clk, rst (async, active-high), clear (sync, wins over inc),
//        inc (add 'add' this cycle), add (increment value), cnt (count).
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] add,
  output logic [W-1:0] cnt
);

  logic [W:0] sum_c;

  assign sum_c = {1'b0, cnt} + {1'b0, add};

  // Carry out of the sum means the result would wrap: stick at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sum_c[W] ? '1 : sum_c[W-1:0];
    end
  end

endmodule

// File: rtl/pkt_rx_checker.sv
// Drains frames from the MAC receive interface, checks framing, length and
// an incrementing 64-bit payload pattern, and keeps saturating statistics.
// Ports: clk_156/async_reset; clear_stats, check_en controls;
//        pkt_rx_* MAC read interface (ren out, rest in);
//        busy, *_cnt statistics and last_len outputs.
module pkt_rx_checker
  import pkt_rx_pkg::*;
#(
  parameter int unsigned MIN_LEN = MIN_LEN_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_156,
  input  logic             async_reset,
  input  logic             clear_stats,
  input  logic             check_en,
  input  logic             pkt_rx_avail,
  output logic             pkt_rx_ren,
  input  logic             pkt_rx_val,
  input  logic [63:0]      pkt_rx_data,
  input  logic             pkt_rx_sop,
  input  logic             pkt_rx_eop,
  input  logic [2:0]       pkt_rx_mod,
  input  logic             pkt_rx_err,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [47:0]      byte_cnt,
  output logic [CNT_W-1:0] mac_err_cnt,
  output logic [CNT_W-1:0] data_err_cnt,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic [CNT_W-1:0] len_err_cnt,
  output logic [15:0]      last_len
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic              in_pkt;
  logic              orphan;
  logic              chk;
  logic              mismatch;
  logic [WC_W-1:0]   wc;
  logic [63:0]       expected;

  logic [3:0]        m_c;
  logic [63:0]       mask_c;
  logic              beat_mis_c;
  logic [WC_W-1:0]   wc_next_c;
  logic [LEN_W-1:0]  len_c;
  logic              done_c;
  logic              frame_mis_c;
  logic              len_bad_c;
  logic              frame_err_c;

  // Beat decode: byte mask of the eop beat, running length and event strobes
  assign m_c         = mod_bytes(pkt_rx_mod);
  assign mask_c      = {64{1'b1}} >> {3'(4'd8 - m_c), 3'b000};
  assign beat_mis_c  = chk & (|((pkt_rx_data ^ expected) &
                                (pkt_rx_eop ? mask_c : {64{1'b1}})));
  assign wc_next_c   = pkt_rx_sop ? WC_W'(1) :
                       ((wc == {WC_W{1'b1}}) ? wc : wc + WC_W'(1));
  assign len_c       = {wc_next_c - WC_W'(1), 3'b000} + LEN_W'(m_c);
  assign done_c      = pkt_rx_val & pkt_rx_eop & (pkt_rx_sop | in_pkt);
  // The sop beat only seeds the pattern, so a single-beat frame never mismatches
  assign frame_mis_c = ~pkt_rx_sop & (mismatch | beat_mis_c);
  assign len_bad_c   = (len_c < LEN_W'(MIN_LEN)) | (len_c > LEN_W'(MAX_LEN));
  // Framing error: sop inside an open frame, or the first beat of an orphan run
  assign frame_err_c = pkt_rx_val & (pkt_rx_sop ? in_pkt : (~in_pkt & ~orphan));

  // Read FSM; GAP forces one idle cycle so avail is re-sampled after the MAC updates it
  always_ff @(posedge clk_156 or posedge async_reset) begin
    if (async_reset) begin
      state      <= IDLE;
      pkt_rx_ren <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pkt_rx_avail) begin
            state      <= READ;
            pkt_rx_ren <= 1'b1;
            busy       <= 1'b1;
          end
        end
        READ: begin
          if (pkt_rx_val && pkt_rx_eop) begin
            state      <= GAP;
            pkt_rx_ren <= 1'b0;
          end
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          pkt_rx_ren <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // Frame tracking and pattern check; runs on every valid beat regardless of FSM state
  always_ff @(posedge clk_156 or posedge async_reset) begin
    if (async_reset) begin
      in_pkt   <= 1'b0;
      orphan   <= 1'b0;
      chk      <= 1'b0;
      mismatch <= 1'b0;
      wc       <= '0;
      expected <= '0;
    end else if (pkt_rx_val) begin
      if (pkt_rx_sop) begin
        in_pkt   <= ~pkt_rx_eop;
        orphan   <= 1'b0;
        chk      <= check_en;
        mismatch <= 1'b0;
        wc       <= WC_W'(1);
        expected <= pkt_rx_data + 64'd1;
      end else if (in_pkt) begin
        in_pkt   <= ~pkt_rx_eop;
        wc       <= wc_next_c;
        expected <= expected + 64'd1;
        mismatch <= mismatch | beat_mis_c;
      end else begin
        orphan   <= 1'b1;
      end
    end
  end

  // Length of the most recent completed frame, clamped to 16 bits
  always_ff @(posedge clk_156 or posedge async_reset) begin
    if (async_reset) begin
      last_len <= '0;
    end else if (clear_stats) begin
      last_len <= '0;
    end else if (done_c) begin
      last_len <= (|len_c[LEN_W-1:16]) ? 16'hFFFF : len_c[15:0];
    end
  end

  sat_counter #(.W(CNT_W)) u_pkt_cnt (
    .clk(clk_156), .rst(async_reset), .clear(clear_stats),
    .inc(done_c), .add(CNT_ONE), .cnt(pkt_cnt)
  );

  sat_counter #(.W(48)) u_byte_cnt (
    .clk(clk_156), .rst(async_reset), .clear(clear_stats),
    .inc(done_c), .add(48'(len_c)), .cnt(byte_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mac_err_cnt (
    .clk(clk_156), .rst(async_reset), .clear(clear_stats),
    .inc(done_c & pkt_rx_err), .add(CNT_ONE), .cnt(mac_err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_data_err_cnt (
    .clk(clk_156), .rst(async_reset), .clear(clear_stats),
    .inc(done_c & frame_mis_c), .add(CNT_ONE), .cnt(data_err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_frame_err_cnt (
    .clk(clk_156), .rst(async_reset), .clear(clear_stats),
    .inc(frame_err_c), .add(CNT_ONE), .cnt(frame_err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_len_err_cnt (
    .clk(clk_156), .rst(async_reset), .clear(clear_stats),
    .inc(done_c & len_bad_c), .add(CNT_ONE), .cnt(len_err_cnt)
  );

endmodule

// File: tb/tb_pkt_rx_checker.sv
// Scoreboard bench for pkt_rx_checker: a MAC model feeds queued beats on ren,
// a frame-level reference model predicts the statistics after each read burst,
// and a monitor compares them when busy drops.
module tb_pkt_rx_checker;

  localparam int CW = 8;

  logic          clk_156 = 1'b0;
  logic          async_reset;
  logic          clear_stats;
  logic          check_en;
  logic          pkt_rx_avail;
  logic          pkt_rx_ren;
  logic          pkt_rx_val;
  logic [63:0]   pkt_rx_data;
  logic          pkt_rx_sop;
  logic          pkt_rx_eop;
  logic [2:0]    pkt_rx_mod;
  logic          pkt_rx_err;
  logic          busy;
  logic [CW-1:0] pkt_cnt;
  logic [47:0]   byte_cnt;
  logic [CW-1:0] mac_err_cnt;
  logic [CW-1:0] data_err_cnt;
  logic [CW-1:0] frame_err_cnt;
  logic [CW-1:0] len_err_cnt;
  logic [15:0]   last_len;

  pkt_rx_checker #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(CW)) dut (
    .clk_156(clk_156), .async_reset(async_reset), .clear_stats(clear_stats),
    .check_en(check_en), .pkt_rx_avail(pkt_rx_avail), .pkt_rx_ren(pkt_rx_ren),
    .pkt_rx_val(pkt_rx_val), .pkt_rx_data(pkt_rx_data), .pkt_rx_sop(pkt_rx_sop),
    .pkt_rx_eop(pkt_rx_eop), .pkt_rx_mod(pkt_rx_mod), .pkt_rx_err(pkt_rx_err),
    .busy(busy), .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt), .mac_err_cnt(mac_err_cnt),
    .data_err_cnt(data_err_cnt), .frame_err_cnt(frame_err_cnt),
    .len_err_cnt(len_err_cnt), .last_len(last_len)
  );

  always #5 clk_156 = ~clk_156;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
    logic        clr;
  } beat_t;

  typedef struct {
    longint unsigned pkt;
    longint unsigned bytes;
    longint unsigned mac;
    longint unsigned dat;
    longint unsigned frm;
    longint unsigned len;
    longint unsigned last;
  } stats_t;

  beat_t  bq[$];
  stats_t sbq[$];
  stats_t model;
  int     checks = 0;
  int     errors = 0;
  int     beats_sent = 0;
  int     ren_cycles = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned sadd(input longint unsigned a, input longint unsigned b,
                                           input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    return (a + b > mx) ? mx : a + b;
  endfunction

  function automatic void model_clear();
    model = '{default: 0};
  endfunction

  // Reference: statistics of one completed frame from its byte length and flags
  function automatic void model_frame(input int len, input bit err, input bit dmis, input bit clr);
    model.pkt   = sadd(model.pkt, 1, CW);
    model.bytes = sadd(model.bytes, longint'(len), 48);
    model.last  = longint'(len);
    if (err) model.mac = sadd(model.mac, 1, CW);
    if (dmis) model.dat = sadd(model.dat, 1, CW);
    if (len < 64 || len > 1518) model.len = sadd(model.len, 1, CW);
    if (clr) model_clear();
  endfunction

  // Push an unterminated frame of n beats (abandoned by the next sop)
  function automatic void push_partial(input int n, input logic [63:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + 64'(i);
      b.sop = (i == 0);
      b.eop = 1'b0;
      b.mod = 3'($urandom_range(0, 7));
      b.err = 1'b0;
      b.clr = 1'b0;
      bq.push_back(b);
    end
    model.frm = sadd(model.frm, 1, CW);
  endfunction

  // Push a complete frame; beat cb (if >=0) gets bit cbit flipped
  function automatic void push_frame(input int len, input logic [63:0] base, input bit err,
                                     input int cb, input int cbit, input bit clr);
    beat_t b;
    int    nb;
    int    last_bytes;
    bit    dmis;
    nb = (len + 7) / 8;
    last_bytes = len - 8 * (nb - 1);
    for (int i = 0; i < nb; i++) begin
      b.data = base + 64'(i);
      if (i == cb) b.data[cbit] = ~b.data[cbit];
      b.sop = (i == 0);
      b.eop = (i == nb - 1);
      b.mod = b.eop ? 3'(len % 8) : 3'($urandom_range(0, 7));
      b.err = b.eop ? err : 1'b0;
      b.clr = b.eop ? clr : 1'b0;
      bq.push_back(b);
    end
    dmis = check_en && cb >= 1 && cb < nb && (cb < nb - 1 || cbit < 8 * last_bytes);
    model_frame(len, err, dmis, clr);
  endfunction

  // Post the expected statistics for this burst and wait for it to drain
  task automatic finish_burst();
    int t;
    sbq.push_back(model);
    t = 0;
    while ((bq.size() != 0 || busy || sbq.size() != 0) && t < 5000) begin
      @(negedge clk_156);
      t++;
    end
    if (t >= 5000) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: got busy=%0d beats_left=%0d expected drained", busy, bq.size());
      bq.delete();
      sbq.delete();
    end
    repeat (2) @(negedge clk_156);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pkt_cnt"}, pkt_cnt, 0);
    chk({tag, "_byte_cnt"}, byte_cnt, 0);
    chk({tag, "_mac_err_cnt"}, mac_err_cnt, 0);
    chk({tag, "_data_err_cnt"}, data_err_cnt, 0);
    chk({tag, "_frame_err_cnt"}, frame_err_cnt, 0);
    chk({tag, "_len_err_cnt"}, len_err_cnt, 0);
    chk({tag, "_last_len"}, last_len, 0);
    chk({tag, "_ren"}, pkt_rx_ren, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // MAC model: a beat follows one cycle after each ren while beats are queued
  initial begin
    logic  ren_s;
    beat_t b;
    pkt_rx_avail = 1'b0;
    pkt_rx_val = 1'b0;
    pkt_rx_data = '0;
    pkt_rx_sop = 1'b0;
    pkt_rx_eop = 1'b0;
    pkt_rx_mod = '0;
    pkt_rx_err = 1'b0;
    clear_stats = 1'b0;
    forever begin
      @(negedge clk_156);
      ren_s = pkt_rx_ren;
      if (ren_s) ren_cycles++;
      @(posedge clk_156);
      #1;
      if (ren_s && bq.size() != 0) begin
        b = bq.pop_front();
        pkt_rx_val = 1'b1;
        pkt_rx_data = b.data;
        pkt_rx_sop = b.sop;
        pkt_rx_eop = b.eop;
        pkt_rx_mod = b.mod;
        pkt_rx_err = b.err;
        clear_stats = b.clr;
        beats_sent++;
      end else begin
        pkt_rx_val = 1'b0;
        pkt_rx_sop = 1'b0;
        pkt_rx_eop = 1'b0;
        pkt_rx_err = 1'b0;
        pkt_rx_data = {$urandom, $urandom};
        clear_stats = 1'b0;
      end
      pkt_rx_avail = (bq.size() != 0);
    end
  end

  // Monitor: compare statistics against the scoreboard whenever a read burst ends
  initial begin
    bit     prev;
    stats_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk_156);
      if (async_reset) begin
        prev = 1'b0;
      end else begin
        if (prev && !busy) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_burst_end: got busy drop expected none (t=%0t)", $time);
          end else begin
            e = sbq.pop_front();
            chk("pkt_cnt", pkt_cnt, e.pkt);
            chk("byte_cnt", byte_cnt, e.bytes);
            chk("mac_err_cnt", mac_err_cnt, e.mac);
            chk("data_err_cnt", data_err_cnt, e.dat);
            chk("frame_err_cnt", frame_err_cnt, e.frm);
            chk("len_err_cnt", len_err_cnt, e.len);
            chk("last_len", last_len, e.last);
          end
        end
        prev = busy;
      end
    end
  end

  initial begin
    int t;
    int len;
    int nb;
    int cb;
    async_reset = 1'b1;
    check_en = 1'b1;
    model_clear();
    repeat (3) @(negedge clk_156);
    check_all_zero("reset");
    @(posedge clk_156);
    #1 async_reset = 1'b0;
    repeat (2) @(negedge clk_156);

    // 64-byte frame, data 0x10..0x17
    ren_cycles = 0;
    push_frame(64, 64'h10, 1'b0, -1, 0, 1'b0);
    finish_burst();
    chk("ren_high_cycles", longint'(ren_cycles), 9);

    // 61-byte frame with bit 40 of beat 3 flipped, then a flip outside the eop byte mask
    push_frame(61, {$urandom, $urandom}, 1'b0, 3, 40, 1'b0);
    finish_burst();
    push_frame(61, {$urandom, $urandom}, 1'b0, 7, 50, 1'b0);
    finish_burst();

    // Missing eop: sop at beat 4 restarts with a proper 64-byte frame
    push_partial(4, {$urandom, $urandom});
    push_frame(64, {$urandom, $urandom}, 1'b0, -1, 0, 1'b0);
    finish_burst();

    // Runt and giant frames, MAC error on the giant
    push_frame(40, {$urandom, $urandom}, 1'b0, -1, 0, 1'b0);
    finish_burst();
    push_frame(1600, {$urandom, $urandom}, 1'b1, -1, 0, 1'b0);
    finish_burst();

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      check_en = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       len = $urandom_range(1, 63);
        1:       len = $urandom_range(1519, 1600);
        default: len = $urandom_range(64, 1518);
      endcase
      nb = (len + 7) / 8;
      cb = (nb >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, nb - 1) : -1;
      if ($urandom_range(0, 3) == 0) push_partial($urandom_range(1, 5), {$urandom, $urandom});
      push_frame(len, {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0), cb,
                 $urandom_range(0, 63), 1'b0);
      finish_burst();
    end

    // Saturation with single-beat runts, then clear on the same cycle as an eop
    check_en = 1'b1;
    for (int k = 0; k < 300; k++) begin
      push_frame($urandom_range(1, 8), {$urandom, $urandom}, 1'($urandom_range(0, 1)), -1, 0,
                 1'b0);
      finish_burst();
    end
    chk("pkt_cnt_saturated", pkt_cnt, (64'd1 << CW) - 1);
    push_frame(64, {$urandom, $urandom}, 1'b1, -1, 0, 1'b1);
    finish_burst();

    // Reset in the middle of a 160-byte frame; the tail becomes one orphan run
    beats_sent = 0;
    push_frame(160, {$urandom, $urandom}, 1'b0, -1, 0, 1'b0);
    t = 0;
    while (beats_sent < 6 && t < 1000) begin
      @(negedge clk_156);
      t++;
    end
    chk("reset_wait_beats", longint'(beats_sent >= 6), 1);
    @(posedge clk_156);
    #1 async_reset = 1'b1;
    @(negedge clk_156);
    check_all_zero("midreset");
    @(posedge clk_156);
    #1 async_reset = 1'b0;
    model_clear();
    model.frm = 1;
    finish_burst();
    push_frame(64, {$urandom, $urandom}, 1'b0, -1, 0, 1'b0);
    finish_burst();

    chk("scoreboard_empty", longint'(sbq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_rx_checker.md
Name: pkt_rx_checker

Overview:
- Consumer of the 10GbE MAC user-side receive packet interface (pkt_rx_*) in the XGETH tester; the MAC writes, this block reads.
- Runs on clk_156 beside the MAC/PCS wrapper.
- Drains received frames and validates framing, length and an incrementing 64-bit payload pattern.
- Accumulates saturating statistics for the tester's register bank.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes.
- MAX_LEN, 1518, maximum legal frame length in bytes.
- CNT_W, 32, width of packet/error counters.

Ports:
- clk_156  in  1  156.25 MHz clock; the only clock.
- async_reset  in  1  asynchronous reset, active-high.
- clear_stats  in  1  synchronous clear of all counters and last_len.
- check_en  in  1  enable payload pattern check.
- pkt_rx_avail  in  1  MAC has at least one complete frame queued.
- pkt_rx_ren  out  1  read enable to MAC.
- pkt_rx_val  in  1  data beat valid; arrives 1 cycle after the ren that requested it.
- pkt_rx_data  in  64  beat data; byte lane 0 = [7:0].
- pkt_rx_sop  in  1  first beat of frame.
- pkt_rx_eop  in  1  last beat of frame.
- pkt_rx_mod  in  3  valid bytes in eop beat; 0 means 8.
- pkt_rx_err  in  1  MAC-flagged bad frame (CRC/fault), qualified with eop.
- busy  out  1  high while state is not IDLE.
- pkt_cnt  out  CNT_W  frames completed (eop seen).
- byte_cnt  out  48  bytes of completed frames.
- mac_err_cnt  out  CNT_W  frames with pkt_rx_err.
- data_err_cnt  out  CNT_W  frames with at least one pattern mismatch.
- frame_err_cnt  out  CNT_W  framing violations.
- len_err_cnt  out  CNT_W  frames outside [MIN_LEN, MAX_LEN].
- last_len  out  16  length of most recent completed frame.

Behaviour:
- Reset: all outputs, counters, last_len and pkt_rx_ren are 0; state is IDLE.
- clear_stats zeroes counters and last_len the next cycle; if it coincides with an increment, the clear wins.
- Counters saturate at all-ones; byte_cnt saturates at 2^48-1.
- FSM, all registered:
  - IDLE: ren=0. Go to READ when pkt_rx_avail=1.
  - READ: ren=1. Go to GAP on a val&eop beat.
  - GAP: ren=0 for exactly 1 cycle, then IDLE. This guarantees avail is re-sampled after the MAC updates it.
- Beat processing is independent of FSM state: any val beat is processed, because it may trail a ren issued the previous cycle.
- Internal in_pkt flag: set on val&sop, cleared on val&eop.
- Word count wc: 16 bits, saturating.
- Frame length = 8*(wc-1) + (mod==0 ? 8 : mod).
- val&sop while in_pkt=1 (missing eop):
  - frame_err_cnt+1.
  - The open frame is abandoned and not counted in pkt_cnt.
  - The new frame starts.
- val without sop while in_pkt=0: frame_err_cnt+1 once per orphan run; beats discarded until the next sop.
- val&sop&eop: single-beat frame, length = mod-derived value.
  - A length below MIN_LEN gives len_err_cnt+1.
- On eop of a valid frame:
  - pkt_cnt+1, byte_cnt+=len, last_len<=len.
  - mac_err_cnt+1 if pkt_rx_err.
  - len_err_cnt+1 if len<MIN_LEN or len>MAX_LEN.
  - data_err_cnt+1 if the mismatch flag is set.
  - All these updates are visible the cycle after the eop beat.
- Pattern check, when check_en=1:
  - The sop beat seeds expected = data+1 (64-bit wrap).
  - Each later beat is compared with expected, then expected+=1.
  - The eop beat compares only bits [8*m-1:0], where m = mod-derived byte count.
  - Any mismatch sets a sticky per-frame flag, cleared at the next sop.
  - check_en is sampled at sop and held for the frame.
- async_reset mid-frame: everything returns to reset values. The following beats are orphans until the next sop, and each orphan run counts one frame error.

Decomposition:
- Shared package pkt_rx_pkg holds:
  - state encoding (IDLE, READ, GAP);
  - the function converting mod to a byte count;
  - MIN_LEN and MAX_LEN defaults.
- One natural sub-module, sat_counter (parametric width, inc, add value, clear, saturate), is instantiated for every statistic.

Test Plan:
- 64-byte frame: 8 beats, data 0x10..0x17, mod=0, avail pulse → ren high 9 cycles; pkt_cnt=1, byte_cnt=64, last_len=64, all error counts 0.
- 61-byte frame, mod=5, beat 3 corrupted in bit 40 → data_err_cnt=1, pkt_cnt=1, last_len=61. Then corrupt a bit above [39:0] of the eop beat only → no data error.
- sop at beat 4 with no prior eop, then a proper 64-byte frame → frame_err_cnt=1, pkt_cnt=1, byte_cnt=64.
- 40-byte frame and 1600-byte frame, with pkt_rx_err on the second eop → len_err_cnt=2, mac_err_cnt=1, pkt_cnt=2.
- Preload counters near all-ones via forced increments → counters stick at max. clear_stats asserted on the same cycle as an eop → counters read 0.
- async_reset asserted mid-frame, beats continue to eop → outputs 0 during reset; frame_err_cnt=1 afterwards; next sop frame counted normally.
